// File: rtl/fta_req_arbiter_pkg.sv
// Shared FTA command-bus types and arbiter mode encoding.
package fta_req_arbiter_pkg;

   localparam int FTA_MAX_CHANNELS = 8;

   typedef enum logic {
      FIXED = 1'b0,
      RR    = 1'b1
   } fta_arb_mode_t;

   typedef struct packed {
      logic [3:0] core;
      logic [3:0] channel;
      logic [7:0] tranid;
   } fta_tranid_t;

   typedef struct packed {
      fta_tranid_t  tid;
      logic         cyc;
      logic         we;
      logic [15:0]  sel;
      logic [31:0]  adr;
      logic [127:0] data1;
   } fta_cmd_request128_t;

   typedef struct packed {
      fta_tranid_t  tid;
      logic         ack;
      logic         rty;
      logic         err;
      logic [31:0]  adr;
      logic [127:0] dat;
   } fta_cmd_response128_t;

   // A response slot carries a real response only when a status bit is set;
   // an all-zero idle slot must not be routed to channel 0.
   function automatic logic resp_valid(input fta_cmd_response128_t r);
      return r.ack | r.rty | r.err;
   endfunction

endpackage

// File: rtl/fta_req_arbiter_rr_pick.sv
// Combinational picker: first set request bit at or after ptr, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      int unsigned j;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int unsigned off = 0; off < N; off++) begin
         j = (32'(ptr) + off) % N;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/fta_req_arbiter.sv
// N-requester arbiter for the single external FTA 128-bit command bus:
// fixed-priority or round-robin grant, lock-held ownership with a
// starvation cap, registered bus request and tid-based response routing.
module fta_req_arbiter
   import fta_req_arbiter_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int MODE     = 0,
   parameter int HOLD_MAX = 16,
   parameter int RW       = $bits(fta_cmd_request128_t),
   parameter int SW       = $bits(fta_cmd_response128_t)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [CHANNELS*RW-1:0] req_i,
   input  logic [CHANNELS-1:0]    lock_i,
   output logic [CHANNELS*SW-1:0] resp_o,
   output logic [RW-1:0]          fta_req,
   input  logic [SW-1:0]          fta_resp,
   output logic [CHANNELS-1:0]    gnt_o,
   output logic                   unmatched_o
);

   localparam int IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int HCW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam fta_arb_mode_t ARB_MODE = (MODE != 0) ? RR : FIXED;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   state_t               state;
   logic [IW-1:0]        owner;
   logic [IW-1:0]        rr_ptr;
   logic [HCW-1:0]       hold_cnt;

   fta_cmd_request128_t  req [CHANNELS];
   fta_cmd_response128_t resp_v [CHANNELS];
   fta_cmd_response128_t resp_s;
   logic [CHANNELS-1:0]  cyc_v;

   logic [IW-1:0]        pick_ptr;
   logic [CHANNELS-1:0]  pick_gnt;
   logic [IW-1:0]        pick_idx;
   logic                 pick_any;

   fta_cmd_request128_t  own_req;
   logic                 own_cyc;
   logic                 own_lock;
   logic                 others_wait;
   logic                 hold_sat;
   logic                 hold_hit;
   logic                 release_now;
   logic                 resp_present;
   logic [IW-1:0]        next_ptr;

   assign resp_s       = fta_cmd_response128_t'(fta_resp);
   assign resp_present = resp_valid(resp_s);

   // Unpack the flat request bus into per-requester structs.
   always_comb begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         req[i]   = fta_cmd_request128_t'(req_i[i*RW +: RW]);
         cyc_v[i] = req[i].cyc;
      end
   end

   // Fixed priority reuses the rotating picker with its start pinned at 0.
   assign pick_ptr = (ARB_MODE == RR) ? rr_ptr : '0;

   rr_pick #(
      .N  (CHANNELS),
      .IW (IW)
   ) u_pick (
      .req (cyc_v),
      .ptr (pick_ptr),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign own_req     = req[owner];
   assign own_cyc     = own_req.cyc;
   assign own_lock    = lock_i[owner];
   assign others_wait = |(cyc_v & ~gnt_o);
   assign hold_sat    = (hold_cnt >= HCW'(HOLD_MAX));
   assign hold_hit    = (HOLD_MAX != 0) && hold_sat;
   // The cap only overrides the lock; an active cyc is never cut short.
   assign release_now = !own_cyc && (!own_lock || hold_hit);
   assign next_ptr    = (owner == IW'(CHANNELS - 1)) ? '0 : owner + 1'b1;

   // Grant FSM with registered bus request, grant vector and unmatched flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= '0;
         rr_ptr      <= '0;
         hold_cnt    <= '0;
         gnt_o       <= '0;
         fta_req     <= '0;
         unmatched_o <= 1'b0;
      end else begin
         unmatched_o <= resp_present && (int'(resp_s.tid.channel) >= CHANNELS);
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state    <= OWN;
                  owner    <= pick_idx;
                  gnt_o    <= pick_gnt;
                  fta_req  <= req[pick_idx];
                  hold_cnt <= '0;
               end else begin
                  fta_req  <= '0;
               end
            end
            OWN: begin
               if (release_now) begin
                  state    <= IDLE;
                  gnt_o    <= '0;
                  fta_req  <= '0;
                  rr_ptr   <= next_ptr;
                  hold_cnt <= '0;
               end else begin
                  fta_req <= own_cyc ? own_req : '0;
                  if (others_wait && !hold_sat)
                     hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Retry every non-owner with its own tid; a valid response overrides its channel.
   always_comb begin
      resp_o = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         resp_v[i] = '0;
         if (!gnt_o[i]) begin
            resp_v[i].rty = 1'b1;
            resp_v[i].tid = req[i].tid;
         end
         if (resp_present && (int'(resp_s.tid.channel) == int'(i)))
            resp_v[i] = resp_s;
         resp_o[i*SW +: SW] = resp_v[i];
      end
   end

endmodule
